// File: rtl/sorter_pkg.sv
// sorter_pkg: modulation codes, symbol-block periods and scheduler state encoding
package sorter_pkg;
  localparam logic [1:0] M_QPSK = 2'b00;
  localparam logic [1:0] M_QAM16 = 2'b01;
  localparam logic [1:0] M_QAM64 = 2'b10;
  localparam logic [1:0] M_QAM256 = 2'b11;
  localparam int PERIOD_QPSK = 1;
  localparam int PERIOD_QAM16 = 5;
  typedef enum logic [2:0] {S_IDLE, S_ARB, S_RUN, S_WAIT, S_REL} state_t;
endpackage

// File: rtl/sched_rr_pick.sv
// sched_rr_pick: combinational round-robin picker
// Ports: req (request vector), ptr (highest-priority index), win (winner index), valid (any request)
module sched_rr_pick
  import sorter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IW = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [IW-1:0]    win,
  output logic             valid
);
  always_comb begin
    win = '0;
    valid = |req;
    for (int k = N_REQ - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % N_REQ]) win = IW'((int'(ptr) + k) % N_REQ);
  end
endmodule

// File: rtl/sorter_sched.sv
// sorter_sched: round-robin scheduler sharing one sorter between N_REQ requesters
// Ports: clk, rst (async, active-high); req/req_m/req_blocks from requesters;
// gnt, xfer_done to requesters; srt_start/srt_m to sorter, srt_done from sorter;
// busy, err_unsup, err_timeout status pulses.
// Build option: SORTER_SCHED_PRIO0_EN gives requester 0 strict priority.
module sorter_sched
  import sorter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int BLK_W = 8,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [2*N_REQ-1:0]     req_m,
  input  logic [BLK_W*N_REQ-1:0] req_blocks,
  output logic [N_REQ-1:0]       gnt,
  output logic                   srt_start,
  output logic [1:0]             srt_m,
  input  logic                   srt_done,
  output logic                   busy,
  output logic [N_REQ-1:0]       xfer_done,
  output logic                   err_unsup,
  output logic                   err_timeout
);
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = BLK_W + 3;
  localparam int TW = $clog2(TIMEOUT + 1);
  state_t state, nxt;
  logic [IW-1:0] ptr, idx, win, win_sel;
  logic win_ok, ok_sel, unsup, unsup_new, tmo;
  logic [N_REQ-1:0] pick_req, onehot;
  logic [1:0] m, m_new;
  logic [BLK_W-1:0] blk_raw;
  logic [CW-1:0] blk_eff, load, cnt;
  logic [TW-1:0] wcnt;

`ifdef SORTER_SCHED_PRIO0_EN
  // requester 0 bypasses the rotation; the others share it
  assign pick_req = req & ~N_REQ'(1);
  assign win_sel = req[0] ? '0 : win;
  assign ok_sel = |req;
`else
  assign pick_req = req;
  assign win_sel = win;
  assign ok_sel = win_ok;
`endif

  sched_rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
    .req(pick_req),
    .ptr(ptr),
    .win(win),
    .valid(win_ok)
  );

  // a zero block count still sorts one block
  always_comb begin
    m_new = req_m[2*win_sel +: 2];
    blk_raw = req_blocks[BLK_W*win_sel +: BLK_W];
    blk_eff = (blk_raw == '0) ? CW'(1) : CW'(blk_raw);
    load = ((m_new == M_QAM16) ? blk_eff * CW'(PERIOD_QAM16) : blk_eff * CW'(PERIOD_QPSK)) - CW'(1);
    unsup_new = (m_new == M_QAM64) || (m_new == M_QAM256);
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= S_IDLE;
    else state <= nxt;

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE: nxt = |req ? S_ARB : S_IDLE;
      S_ARB: nxt = !ok_sel ? S_IDLE : unsup_new ? S_REL : S_RUN;
      S_RUN: nxt = (cnt == '0) ? S_WAIT : S_RUN;
      S_WAIT: nxt = (srt_done || wcnt == TW'(TIMEOUT - 1)) ? S_REL : S_WAIT;
      S_REL: nxt = |req ? S_ARB : S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ptr <= '0;
      idx <= '0;
      m <= '0;
      cnt <= '0;
      wcnt <= '0;
      unsup <= 1'b0;
      tmo <= 1'b0;
    end else if (state == S_ARB && ok_sel) begin
      idx <= win_sel;
      m <= m_new;
      cnt <= load;
      unsup <= unsup_new;
      wcnt <= '0;
      tmo <= 1'b0;
    end else if (state == S_RUN) begin
      cnt <= cnt - CW'(1);
    end else if (state == S_WAIT) begin
      wcnt <= wcnt + TW'(1);
      tmo <= !srt_done && wcnt == TW'(TIMEOUT - 1);
    end else if (state == S_REL) begin
      ptr <= (idx == IW'(N_REQ - 1)) ? '0 : idx + IW'(1);
      unsup <= 1'b0;
      tmo <= 1'b0;
    end

  always_comb begin
    onehot = N_REQ'(1) << idx;
    gnt = (state == S_RUN || state == S_WAIT || state == S_REL) ? onehot : '0;
    srt_start = state == S_RUN;
    srt_m = (state == S_RUN || state == S_WAIT) ? m : 2'b00;
    busy = state != S_IDLE;
    xfer_done = (state == S_REL) ? onehot : '0;
    err_unsup = state == S_REL && unsup;
    err_timeout = state == S_REL && tmo;
  end
endmodule

// File: tb/tb_sorter_sched.sv
// tb_sorter_sched: randomized transaction-level check of sorter_sched against a reference model
module tb_sorter_sched;
  localparam int N = 4;
  localparam int BW = 8;
  localparam int TO = 255;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] req = '0;
  logic [2*N-1:0] req_m = '0;
  logic [BW*N-1:0] req_blocks = '0;
  logic srt_done = 1'b0;
  logic [N-1:0] gnt, xfer_done;
  logic srt_start, busy, err_unsup, err_timeout;
  logic [1:0] srt_m;
  int n_chk = 0;
  int n_fail = 0;
  int mptr = 0;

  sorter_sched #(.N_REQ(N), .BLK_W(BW), .TIMEOUT(TO)) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .req_m(req_m),
    .req_blocks(req_blocks),
    .gnt(gnt),
    .srt_start(srt_start),
    .srt_m(srt_m),
    .srt_done(srt_done),
    .busy(busy),
    .xfer_done(xfer_done),
    .err_unsup(err_unsup),
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cfg(input int i, input int mm, input int blk);
    req_m[2*i +: 2] = 2'(mm);
    req_blocks[BW*i +: BW] = 8'(blk);
  endtask

  function automatic int pick(input logic [N-1:0] r, input int p);
`ifdef SORTER_SCHED_PRIO0_EN
    if (r[0]) return 0;
    r[0] = 1'b0;
`endif
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // one full transfer from the cycle after req is presented through REL;
  // dly = wait cycle on which srt_done is returned, 0 = never
  task automatic xfer(input int dly, input bit drop);
    int w, cyc, st, wt, exp_st, exp_wt, blk;
    logic [1:0] mm;
    w = pick(req, mptr);
    mm = req_m[2*w +: 2];
    blk = int'(req_blocks[BW*w +: BW]);
    exp_st = (blk == 0 ? 1 : blk) * (mm == 2'b01 ? 5 : 1);
    @(negedge clk);
    cyc = 0;
    while (gnt == '0 && cyc < 4) begin
      @(negedge clk);
      cyc++;
    end
    check("grant", gnt, 1 << w);
    if (mm[1]) begin
      check("unsup_start", srt_start, 0);
      check("unsup_err", err_unsup, 1);
      check("unsup_xfer", xfer_done, 1 << w);
      check("unsup_tmo", err_timeout, 0);
    end else begin
      st = 0;
      while (srt_start && st < 2000) begin
        check("run_m", srt_m, mm);
        check("run_gnt", gnt, 1 << w);
        st++;
        srt_done = 1'($urandom_range(0, 1));
        if (drop && $urandom_range(0, 3) == 0) req[w] = 1'b0;
        @(negedge clk);
      end
      check("run_len", st, exp_st);
      wt = 0;
      srt_done = (dly == 1);
      while (xfer_done == '0 && wt < TO + 5) begin
        check("wait_m", srt_m, mm);
        check("wait_start", srt_start, 0);
        wt++;
        @(negedge clk);
        srt_done = (dly == wt + 1);
      end
      exp_wt = (dly >= 1 && dly <= TO) ? dly : TO;
      check("wait_len", wt, exp_wt);
      check("rel_tmo", err_timeout, (dly >= 1 && dly <= TO) ? 0 : 1);
      check("rel_xfer", xfer_done, 1 << w);
      check("rel_gnt", gnt, 1 << w);
      check("rel_unsup", err_unsup, 0);
    end
    srt_done = 1'b0;
    mptr = (w + 1) % N;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_gnt", gnt, 0);
    check("rst_start", srt_start, 0);
    check("rst_m", srt_m, 0);
    check("rst_busy", busy, 0);
    check("rst_xfer", xfer_done, 0);
    check("rst_unsup", err_unsup, 0);
    check("rst_tmo", err_timeout, 0);
    rst = 1'b0;
    req = 4'b0001; cfg(0, 0, 3);
    xfer(1, 0);
    req = 4'b0010; cfg(1, 1, 2);
    xfer(2, 0);
    req = 4'b0100; cfg(2, 2, 4);
    xfer(1, 0);
    req = 4'b1000; cfg(3, 0, 1);
    xfer(0, 0);
    req = 4'b1111;
    for (int i = 0; i < N; i++) cfg(i, 0, 1);
    repeat (5) xfer(1, 0);
    req = 4'b0010; cfg(1, 0, 0);
    xfer(TO, 0);
    req = 4'b0001; cfg(0, 0, 5);
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_start", srt_start, 1);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("arst_start", srt_start, 0);
    check("arst_gnt", gnt, 0);
    check("arst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    mptr = 0;
    req = 4'b1010; cfg(1, 0, 1); cfg(3, 0, 1);
    xfer(1, 0);
    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        req = '0;
        @(negedge clk);
        check("gap_busy", busy, 0);
        check("gap_gnt", gnt, 0);
      end
      req = 4'($urandom_range(1, 15));
      for (int i = 0; i < N; i++) cfg(i, $urandom_range(0, 3), $urandom_range(0, 4));
      xfer(($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 4), 1);
    end
`ifdef SORTER_SCHED_PRIO0_EN
    req = 4'b1001; cfg(0, 0, 1); cfg(3, 0, 1);
    repeat (4) xfer(1, 0);
`endif
    req = '0;
    @(negedge clk);
    @(negedge clk);
    check("end_busy", busy, 0);
    check("end_gnt", gnt, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
